// File: rtl/branch_sequencer_if.sv
// Fetch/execute <-> PC sequencer bus. The master side reports retirement and
// redirect information; the slave side (the sequencer) returns the PC and status flags.
interface branch_sequencer_if;
  logic        advance;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_delay_slot;
  logic        active;
  logic        fault;

  modport master (
    output advance, branch_valid, branch_taken, branch_addr, jump_valid, jump_target,
    input  pc, pc_plus4, in_delay_slot, active, fault
  );

  modport slave (
    input  advance, branch_valid, branch_taken, branch_addr, jump_valid, jump_target,
    output pc, pc_plus4, in_delay_slot, active, fault
  );
endinterface

// File: rtl/branch_sequencer.sv
// MIPS PC sequencer: owns the PC, enforces a single branch delay slot,
// halts on a redirect to HALT_ADDR and flags misaligned or nested redirects.
module branch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic               clk,
  input logic               reset,
  branch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {RUN, DELAY, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pending;
  logic        ds_q;
  logic        active_q;
  logic        fault_q;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_next_seq;

  // Jump wins over a simultaneously taken branch.
  assign redirect    = bus.jump_valid | (bus.branch_valid & bus.branch_taken);
  assign target      = bus.jump_valid ? bus.jump_target : bus.branch_addr;
  assign pc_next_seq = pc_q + 32'd4;

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_next_seq;
  assign bus.in_delay_slot = ds_q;
  assign bus.active        = active_q;
  assign bus.fault         = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc_q     <= RESET_VECTOR;
      pending  <= 32'd0;
      ds_q     <= 1'b0;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else if (bus.advance) begin
      case (state)
        RUN: begin
          if (!redirect) begin
            pc_q <= pc_next_seq;
          end else if (target[1:0] != 2'b00) begin
            fault_q  <= 1'b1;
            active_q <= 1'b0;
            state    <= HALT;
          end else begin
            pending <= target;
            pc_q    <= pc_next_seq;
            ds_q    <= 1'b1;
            state   <= DELAY;
          end
        end
        DELAY: begin
          // A redirect from the delay slot is dropped; the earlier target still wins.
          pc_q <= pending;
          ds_q <= 1'b0;
          if (redirect) fault_q <= 1'b1;
          if (pending == HALT_ADDR) begin
            active_q <= 1'b0;
            state    <= HALT;
          end else begin
            state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed scenarios plus random
// retirement streams checked against a queue-based behavioural model.
module tb_branch_sequencer;
  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h00000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_sequencer_if bif();

  branch_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ds;
    logic        active;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model: architectural PC plus a queue of outstanding delay-slot targets.
  logic [31:0] m_pc;
  logic [31:0] m_slot[$];
  logic        m_halt, m_active, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each retire cycle's expected state is compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (!reset && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",            bif.pc,                   e.pc);
      chk("pc_plus4",      bif.pc_plus4,             e.pc + 32'd4);
      chk("in_delay_slot", {31'd0, bif.in_delay_slot}, {31'd0, e.ds});
      chk("active",        {31'd0, bif.active},      {31'd0, e.active});
      chk("fault",         {31'd0, bif.fault},       {31'd0, e.fault});
    end
  end

  task automatic model_reset();
    m_pc = RV;
    m_slot.delete();
    m_halt = 1'b0;
    m_active = 1'b1;
    m_fault = 1'b0;
  endtask

  task automatic idle();
    bif.advance = 1'b0; bif.branch_valid = 1'b0; bif.branch_taken = 1'b0;
    bif.jump_valid = 1'b0; bif.branch_addr = 32'd0; bif.jump_target = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("reset pc",     bif.pc, RV);
    chk("reset ds",     {31'd0, bif.in_delay_slot}, 32'd0);
    chk("reset active", {31'd0, bif.active}, 32'd1);
    chk("reset fault",  {31'd0, bif.fault}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic adv, input logic bv, input logic bt, input logic [31:0] ba,
                      input logic jv, input logic [31:0] jt);
    logic        redir;
    logic [31:0] tgt, nxt;
    exp_t        e;
    @(negedge clk);
    bif.advance = adv; bif.branch_valid = bv; bif.branch_taken = bt;
    bif.branch_addr = ba; bif.jump_valid = jv; bif.jump_target = jt;
    redir = jv | (bv & bt);
    tgt   = jv ? jt : ba;
    if (adv && !m_halt) begin
      if (m_slot.size() > 0) begin
        if (redir) m_fault = 1'b1;
        nxt  = m_slot.pop_front();
        m_pc = nxt;
        if (nxt == HALT) begin m_halt = 1'b1; m_active = 1'b0; end
      end else if (redir && (tgt % 4 != 0)) begin
        m_fault = 1'b1; m_active = 1'b0; m_halt = 1'b1;
      end else begin
        if (redir) m_slot.push_back(tgt);
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.ds = (m_slot.size() > 0); e.active = m_active; e.fault = m_fault;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] gen_tgt();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'd0;
    if (r == 1) return $urandom() | 32'h1;
    return $urandom() & ~32'h3;
  endfunction

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    do_reset();

    // Taken branch from 0x10 to 0x30
    step(1, 0, 0, 32'd0, 1, 32'h10); run(1);
    step(1, 1, 1, 32'h30, 0, 32'd0); run(1);
    // Not-taken branch from 0x28, then a 5-cycle stall with noisy inputs
    step(1, 0, 0, 32'd0, 1, 32'h28); run(1);
    step(1, 1, 0, 32'h50, 0, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h60, 1, 32'h70);
    // Jump to HALT_ADDR beats a taken branch; core halts and freezes
    step(1, 1, 1, 32'h40, 1, 32'h0); run(1);
    step(1, 1, 1, 32'h80, 1, 32'h90); run(2);

    // Reset while a delay-slot target is pending
    do_reset();
    step(1, 1, 1, 32'h80, 0, 32'd0);
    do_reset();
    run(2);

    // Misaligned target
    do_reset();
    step(1, 1, 1, 32'h31, 0, 32'd0); run(2);
    // Redirect issued from the delay slot is ignored but faults
    do_reset();
    step(1, 1, 1, 32'h100, 0, 32'd0);
    step(1, 0, 0, 32'd0, 1, 32'h200); run(2);

    // Sequential wrap through zero is not a halt
    do_reset();
    step(1, 0, 0, 32'd0, 1, 32'hFFFFFFF8); run(4);

    // Random retirement stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom()),
           gen_tgt(), $urandom_range(0, 5) == 0, gen_tgt());
    end

    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
